// File: rtl/ecg_haar_rx.sv
// ecg_haar_rx: receives a stream of 32-bit unsigned ECG samples through a small
// FIFO. It pairs them as even/odd in arrival order and emits the level-1 Haar
// approximation (even+odd) and detail (even-odd) through a valid/ready port.
// Optional build macro ECG_RX_STATS_EN enables the pair_count statistics
// counter. When the macro is undefined, pair_count is tied to zero.
module ecg_haar_rx #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_ecg,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] out_approx,
    output logic [32:0] out_detail,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pair_count
);

    localparam int DATA_W = 32;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    typedef enum logic {EVEN, ODD} state_t;

    // Approximation: zero-extended sum, one extra bit so it can never overflow.
    function automatic logic [DATA_W:0] haar_sum(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Detail: zero-extended difference as 33-bit two's complement, no saturation.
    function automatic logic signed [DATA_W:0] haar_diff(input logic [DATA_W-1:0] a,
                                                         input logic [DATA_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic                     fifo_empty;
    logic                     push;
    logic [DATA_W-1:0]        head;

    state_t                   state;
    state_t                   state_nxt;
    logic                     pop;
    logic                     load_even;
    logic                     load_out;
    logic                     slot_free;

    logic [DATA_W-1:0]        even_p0;
    logic [DATA_W:0]          approx_p1;
    logic signed [DATA_W:0]   detail_p1;
    logic                     vld_p1;

    // in_ready forced low during reset; a pop in the same cycle never frees a full slot
    assign fifo_empty = (count == '0);
    assign in_ready   = !rst && (count < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign head       = mem[rd_ptr];
    assign slot_free  = !vld_p1 || out_ready;

    // FIFO pointers and occupancy; simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; writes are already gated by in_ready, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_ecg;
    end

    // Pairing FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= EVEN;
        else     state <= state_nxt;
    end

    // Pairing FSM next state: only pops when the FIFO holds data
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_even = 1'b0;
        load_out  = 1'b0;
        case (state)
            EVEN: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_even = 1'b1;
                    state_nxt = ODD;
                end
            end
            ODD: begin
                if (!fifo_empty && slot_free) begin
                    pop       = 1'b1;
                    load_out  = 1'b1;
                    state_nxt = EVEN;
                end
            end
            default: state_nxt = EVEN;
        endcase
    end

    // ---- stage p0: held even sample ----
    // Even register captures the first sample of each pair
    always_ff @(posedge clk) begin
        if (rst)            even_p0 <= '0;
        else if (load_even) even_p0 <= head;
    end

    // ---- stage p1: output pair ----
    // Output data loads with each completed pair and is held while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            approx_p1 <= '0;
            detail_p1 <= '0;
        end else if (load_out) begin
            approx_p1 <= haar_sum(even_p0, head);
            detail_p1 <= haar_diff(even_p0, head);
        end
    end

    // Output valid: set on load, cleared on handshake unless a new pair loads
    always_ff @(posedge clk) begin
        if (rst)           vld_p1 <= 1'b0;
        else if (load_out) vld_p1 <= 1'b1;
        else if (out_ready) vld_p1 <= 1'b0;
    end

    assign out_approx = approx_p1;
    assign out_detail = detail_p1;
    assign out_valid  = vld_p1;

`ifdef ECG_RX_STATS_EN
    logic [15:0] pair_cnt;

    // Counts accepted output pairs, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (rst)                       pair_cnt <= '0;
        else if (vld_p1 && out_ready)  pair_cnt <= pair_cnt + 16'd1;
    end

    assign pair_count = pair_cnt;
`else
    assign pair_count = '0;
`endif

endmodule

// File: tb/tb_ecg_haar_rx.sv
// Randomized and directed bench for ecg_haar_rx. It uses a queue-based reference model.
module tb_ecg_haar_rx;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic [31:0] in_ecg;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] out_approx;
    logic [32:0] out_detail;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pair_count;

    ecg_haar_rx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ecg    (in_ecg),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_approx(out_approx),
        .out_detail(out_detail),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pair_count(pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: pending samples, optional held even sample, output slot
    logic [31:0] q[$];
    bit          m_have_even;
    logic [31:0] m_even;
    bit          m_ov;
    logic [32:0] m_oa;
    logic [32:0] m_od;
    logic [15:0] m_pc;

    bit seq_on = 0;
    int seq_k  = 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_have_even = 0;
        m_even      = '0;
        m_ov        = 0;
        m_oa        = '0;
        m_od        = '0;
        m_pc        = '0;
    endfunction

    // advance the model across one rising edge with the given inputs
    function automatic bit model_step(input bit v, input logic [31:0] d, input bit r, input bit rs);
        bit acc;
        bit loaded;
        logic [31:0] odd;
        if (rs) begin
            model_reset();
            return 0;
        end
        acc    = v && (q.size() < DEPTH);
        loaded = 0;
        if (m_ov && r) m_pc = m_pc + 16'd1;
        if (!m_have_even) begin
            if (q.size() > 0) begin
                m_even      = q.pop_front();
                m_have_even = 1;
            end
        end else if (q.size() > 0 && (!m_ov || r)) begin
            odd         = q.pop_front();
            m_oa        = {1'b0, m_even} + {1'b0, odd};
            m_od        = {1'b0, m_even} - {1'b0, odd};
            m_ov        = 1;
            m_have_even = 0;
            loaded      = 1;
        end
        if (!loaded && r) m_ov = 0;
        if (acc) q.push_back(d);
        return acc;
    endfunction

    // check outputs at the falling edge, drive new inputs, step model, wait for rising edge
    task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit rs, output bit acc);
        logic [15:0] exp_pc;
        @(negedge clk);
`ifdef ECG_RX_STATS_EN
        exp_pc = m_pc;
`else
        exp_pc = 16'd0;
`endif
        chk("in_ready", in_ready, !rst && (q.size() < DEPTH));
        chk("out_valid", out_valid, m_ov);
        chk("out_approx", out_approx, m_oa);
        chk("out_detail", out_detail, m_od);
        chk("pair_count", pair_count, exp_pc);
        in_valid  = v;
        in_ecg    = d;
        out_ready = r;
        rst       = rs;
        if (seq_on && m_ov && r) begin
            chk("seq_approx", out_approx, 33'(4 * seq_k - 1));
            seq_k++;
        end
        acc = model_step(v, d, r, rs);
        @(posedge clk);
    endtask

    task automatic expect_pair(input string tag, input logic [32:0] a, input logic [32:0] dt);
        #2;
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_approx"}, out_approx, a);
        chk({tag, "_detail"}, out_detail, dt);
    endtask

    initial begin
        bit acc;
        int idx;
        logic [31:0] d;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ecg    = '0;
        out_ready = 1'b0;
        model_reset();

        // reset held for a few cycles
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, acc);
        cycle(0, 0, 1, 0, acc);
        #2 chk("ready_after_rst", in_ready, 1'b1);

        // 10,4 -> 14, 6
        cycle(1, 32'd10, 1, 0, acc);
        cycle(1, 32'd4, 1, 0, acc);
        cycle(0, 0, 1, 0, acc);
        expect_pair("p10_4", 33'd14, 33'd6);
        cycle(0, 0, 1, 0, acc);

        // 3,7 -> 10, -4
        cycle(1, 32'd3, 1, 0, acc);
        cycle(1, 32'd7, 1, 0, acc);
        cycle(0, 0, 1, 0, acc);
        expect_pair("p3_7", 33'd10, 33'h1_FFFF_FFFC);
        cycle(0, 0, 1, 0, acc);

        // max, max -> 0x1_FFFF_FFFE, 0
        cycle(1, 32'hFFFF_FFFF, 1, 0, acc);
        cycle(1, 32'hFFFF_FFFF, 1, 0, acc);
        cycle(0, 0, 1, 0, acc);
        expect_pair("pmax", 33'h1_FFFF_FFFE, 33'd0);
        cycle(0, 0, 1, 0, acc);
        cycle(0, 0, 1, 0, acc);

        // back-pressure fill with 1..20, then drain in order
        idx = 1;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 32'(idx), 0, 0, acc);
            if (acc) idx++;
        end
        #2;
        chk("fill_accepted", 32'(idx - 1), 32'd11);
        chk("fill_ready_low", in_ready, 1'b0);
        seq_on = 1;
        seq_k  = 1;
        for (int i = 0; i < 60; i++) begin
            cycle(idx <= 20, 32'(idx), 1, 0, acc);
            if (acc) idx++;
        end
        seq_on = 0;
        chk("seq_pairs", 32'(seq_k - 1), 32'd10);

        // reset mid-pair discards the held sample
        cycle(1, 32'd5, 1, 0, acc);
        cycle(0, 0, 1, 1, acc);
        cycle(1, 32'd8, 1, 0, acc);
        cycle(1, 32'd2, 1, 0, acc);
        cycle(0, 0, 1, 0, acc);
        expect_pair("p_after_rst", 33'd10, 33'd6);
        cycle(0, 0, 1, 0, acc);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 7))
                0:       d = 32'hFFFF_FFFF;
                1:       d = 32'h0;
                default: d = $urandom;
            endcase
            cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 299) == 0, acc);
        end
        cycle(0, 0, 1, 0, acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecg_haar_rx.md
ECG_HAAR_RX -- requirements
Module: ecg_haar_rx

Interface
REQ-001: Parameter DEPTH, default 8, input FIFO depth in 32-bit samples; power of two, 2..64.
REQ-002: clk  input  1  sole clock; all state updates on rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: in_ecg  input  32  unsigned ECG sample from generator.
REQ-005: in_valid  input  1  in_ecg valid this cycle.
REQ-006: in_ready  output  1  block accepts a sample this cycle.
REQ-007: out_approx  output  33  Haar level-1 approximation, unsigned, even+odd.
REQ-008: out_detail  output  33  Haar level-1 detail, two's complement, even-odd.
REQ-009: out_valid  output  1  out_approx/out_detail valid.
REQ-010: out_ready  input  1  downstream accepts the output pair.
REQ-011: pair_count  output  16  number of pairs emitted (see Configuration).

Function
REQ-012: Sample accepted when in_valid and in_ready are both high at a rising edge; it is written to the FIFO at that edge.
REQ-013: in_ready SHALL be high iff FIFO occupancy < DEPTH; no same-cycle bypass when full, even if a pop occurs that cycle.
REQ-014: FIFO pointers wrap modulo DEPTH; occupancy counter range 0..DEPTH; simultaneous push and pop leaves occupancy unchanged.
REQ-015: Pairing FSM states: EVEN (no sample held), ODD (even sample held in internal register).
REQ-016: EVEN: if FIFO non-empty, pop into the even register, go to ODD; else stay.
REQ-017: ODD: if FIFO non-empty and output slot free (out_valid low, or out_ready high this cycle), pop odd sample, load outputs, go to EVEN; else stay in ODD holding the even sample.
REQ-018: out_approx = zero-extended even + zero-extended odd, 33-bit, no overflow possible.
REQ-019: out_detail = zero-extended even - zero-extended odd, 33-bit two's complement, no saturation.
REQ-020: out_valid set at the edge the outputs load; remains high with outputs stable until out_ready is sampled high; cleared then unless a new pair loads at the same edge.
REQ-021: Pop on empty FIFO SHALL never occur; state and pointers unchanged.
REQ-022: Minimum latency: odd sample accepted at edge T, FIFO previously empty, even sample already held -> out_valid high after edge T+1.
REQ-023: Sample order preserved; pairing strictly alternates even/odd from the first sample after reset.
REQ-024: Sustained throughput with out_ready held high: one pair per two cycles (one pop per cycle).

Reset
REQ-025: At a rising edge with rst high: FIFO occupancy 0, pointers 0, FSM to EVEN, even register 0, out_valid 0, out_approx 0, out_detail 0, pair_count 0.
REQ-026: in_ready SHALL read 0 while rst is high and 1 in the first cycle after rst deasserts.
REQ-027: Reset mid-pair discards any held even sample and all FIFO contents; the next accepted sample is treated as even.

Configuration
REQ-028: Macro ECG_RX_STATS_EN defined: pair_count increments by 1 at each edge where out_valid and out_ready are both high, wrapping 0xFFFF -> 0x0000.
REQ-029: Macro ECG_RX_STATS_EN undefined: pair_count port SHALL exist and be tied to constant 0; no counter logic.

Verification
REQ-030: Push 10 then 4, out_ready=1 -> one pair: out_approx 14, out_detail 6 (0x0_0000_0006).
REQ-031: Push 3 then 7 -> out_approx 10, out_detail 0x1_FFFF_FFFC (-4).
REQ-032: Push 0xFFFFFFFF twice -> out_approx 0x1_FFFF_FFFE, out_detail 0.
REQ-033: DEPTH=8, out_ready=0, in_valid held high with samples 1..20 -> in_ready drops once FIFO holds 8; release out_ready -> pairs (1,2),(3,4),... emerge in order, none lost or duplicated, out_approx 3,7,11,...
REQ-034: Accept 5 only, assert rst one cycle, then push 8, 2 -> single pair approx 10, detail 6; 5 never appears.
REQ-035: ECG_RX_STATS_EN defined, 65537 pairs consumed -> pair_count 1; undefined -> pair_count 0 throughout.
